// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline forwarding logic.
// Operand-mux selector encoding and the per-stage destination tag live here.
package mips_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        SEL_REG   = 2'b00,
        SEL_EXMEM = 2'b01,
        SEL_MEMWB = 2'b10
    } fwd_sel_t;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
        logic             ld;
    } stage_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '{rd: REG_ZERO, we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/forward_compare.sv
// Compares one source register against the EX and MEM destination tags and
// returns the operand-mux select plus a flag for a hit on a load still in EX.
module forward_compare
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] i_src,
    input  logic             i_usa,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_ex_we,
    input  logic             i_ex_ld,
    input  logic [REG_W-1:0] i_mem_rd,
    input  logic             i_mem_we,
    output logic [1:0]       o_sel,
    output logic             o_load_hit
);

    logic w_active;
    logic w_ex_hit;
    logic w_mem_hit;

    // $zero is hard-wired, so a write to it must never be forwarded.
    assign w_active   = i_usa && (i_src != REG_ZERO);
    assign w_ex_hit   = w_active && i_ex_we && (i_src == i_ex_rd);
    assign w_mem_hit  = w_active && i_mem_we && (i_src == i_mem_rd);
    assign o_load_hit = w_ex_hit && i_ex_ld;

    always_comb begin
        o_sel = SEL_REG;
        if (w_ex_hit) begin
            o_sel = SEL_EXMEM;
        end else if (w_mem_hit) begin
            o_sel = SEL_MEMWB;
        end
    end

endmodule

// File: rtl/forwarding_unit.sv
// Forwarding selectors and load-use stall for the pipelined MIPS datapath.
// Define FWD_STALL_COUNT_EN to add the contador_stalls stall-cycle counter.
module forwarding_unit
    import mips_pkg::*;
#(
    parameter int REG_ADDR_W = REG_W
`ifdef FWD_STALL_COUNT_EN
    , parameter int CONT_W = 32
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_usa_rs,
    input  logic                  id_usa_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_escreve_reg,
    input  logic                  id_le_mem,
    input  logic                  flush,
    output logic [1:0]            seletor_a,
    output logic [1:0]            seletor_b,
    output logic                  stall
`ifdef FWD_STALL_COUNT_EN
    , output logic [CONT_W-1:0]   contador_stalls
`endif
);

    stage_tag_t       r_ex;
    // The load flag is not needed once an instruction has left EX.
    logic [REG_W-1:0] r_mem_rd;
    logic             r_mem_we;
    logic [1:0]       r_sel_a;
    logic [1:0]       r_sel_b;

    logic [1:0]       w_sel_a;
    logic [1:0]       w_sel_b;
    logic             w_hit_a;
    logic             w_hit_b;
    logic             w_stall;
    logic             w_bubble;
    stage_tag_t       w_id_tag;

    forward_compare u_cmp_rs (
        .i_src      (id_rs),
        .i_usa      (id_usa_rs),
        .i_ex_rd    (r_ex.rd),
        .i_ex_we    (r_ex.we),
        .i_ex_ld    (r_ex.ld),
        .i_mem_rd   (r_mem_rd),
        .i_mem_we   (r_mem_we),
        .o_sel      (w_sel_a),
        .o_load_hit (w_hit_a)
    );

    forward_compare u_cmp_rt (
        .i_src      (id_rt),
        .i_usa      (id_usa_rt),
        .i_ex_rd    (r_ex.rd),
        .i_ex_we    (r_ex.we),
        .i_ex_ld    (r_ex.ld),
        .i_mem_rd   (r_mem_rd),
        .i_mem_we   (r_mem_we),
        .o_sel      (w_sel_b),
        .o_load_hit (w_hit_b)
    );

    // A flushed instruction is discarded anyway, so it never needs to wait.
    assign w_stall  = !flush && (w_hit_a || w_hit_b);
    assign w_bubble = w_stall || flush;

    always_comb begin
        w_id_tag    = TAG_BUBBLE;
        w_id_tag.rd = id_rd;
        w_id_tag.we = id_escreve_reg;
        w_id_tag.ld = id_le_mem;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ex     <= TAG_BUBBLE;
            r_mem_rd <= REG_ZERO;
            r_mem_we <= 1'b0;
            r_sel_a  <= SEL_REG;
            r_sel_b  <= SEL_REG;
        end else begin
            r_mem_rd <= r_ex.rd;
            r_mem_we <= r_ex.we;
            if (w_bubble) begin
                r_ex    <= TAG_BUBBLE;
                r_sel_a <= SEL_REG;
                r_sel_b <= SEL_REG;
            end else begin
                r_ex    <= w_id_tag;
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end
        end
    end

`ifdef FWD_STALL_COUNT_EN
    logic [CONT_W-1:0] r_cont;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cont <= '0;
        end else if (w_stall) begin
            r_cont <= r_cont + 1'b1;
        end
    end

    assign contador_stalls = r_cont;
`endif

    assign seletor_a = r_sel_a;
    assign seletor_b = r_sel_b;
    assign stall     = w_stall;

endmodule

// File: tb/tb_forwarding_unit.sv
// Self-checking bench for forwarding_unit: a reference pipeline model feeds an
// expected-selector queue that is drained after every clock edge.
module tb_forwarding_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_usa_rs, id_usa_rt, id_escreve_reg, id_le_mem, flush;
    logic [1:0] seletor_a, seletor_b;
    logic       stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_q[$];

    logic [4:0] m_ex_rd, m_mem_rd;
    logic       m_ex_we, m_ex_ld, m_mem_we;

`ifdef FWD_STALL_COUNT_EN
    logic [3:0] contador_stalls;
    logic [3:0] m_cnt;

    forwarding_unit #(.REG_ADDR_W(5), .CONT_W(4)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt),
        .id_rd(id_rd), .id_escreve_reg(id_escreve_reg), .id_le_mem(id_le_mem),
        .flush(flush), .seletor_a(seletor_a), .seletor_b(seletor_b), .stall(stall),
        .contador_stalls(contador_stalls)
    );
`else
    forwarding_unit #(.REG_ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt),
        .id_rd(id_rd), .id_escreve_reg(id_escreve_reg), .id_le_mem(id_le_mem),
        .flush(flush), .seletor_a(seletor_a), .seletor_b(seletor_b), .stall(stall)
    );
`endif

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] s, input logic u);
        if (!u || s == 5'd0) return 2'b00;
        if (m_ex_we && s == m_ex_rd) return 2'b01;
        if (m_mem_we && s == m_mem_rd) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_ex_rd = 0; m_ex_we = 0; m_ex_ld = 0;
        m_mem_rd = 0; m_mem_we = 0;
`ifdef FWD_STALL_COUNT_EN
        m_cnt = 0;
`endif
        exp_q.delete();
    endtask

    // One clock with the currently driven ID inputs.
    task automatic cycle(output logic was_stall);
        logic       exp_stall;
        logic [3:0] exp_sel;
        logic [3:0] got;
        #1;
        exp_stall = !flush && m_ex_ld && m_ex_we && (m_ex_rd != 5'd0) &&
                    ((id_usa_rs && id_rs == m_ex_rd) || (id_usa_rt && id_rt == m_ex_rd));
        check("stall", 32'(stall), 32'(exp_stall));
        if (exp_stall || flush) exp_sel = 4'b0000;
        else exp_sel = {exp_fwd(id_rs, id_usa_rs), exp_fwd(id_rt, id_usa_rt)};
        exp_q.push_back(exp_sel);
        @(posedge clock);
        m_mem_rd = m_ex_rd;
        m_mem_we = m_ex_we;
        if (exp_stall || flush) begin
            m_ex_rd = 0; m_ex_we = 0; m_ex_ld = 0;
        end else begin
            m_ex_rd = id_rd; m_ex_we = id_escreve_reg; m_ex_ld = id_le_mem;
        end
`ifdef FWD_STALL_COUNT_EN
        if (exp_stall) m_cnt = m_cnt + 4'd1;
`endif
        #1;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            got = {seletor_a, seletor_b};
            check("sb_selectors", 32'(got), 32'(exp_q.pop_front()));
        end
`ifdef FWD_STALL_COUNT_EN
        check("counter", 32'(contador_stalls), 32'(m_cnt));
`endif
        was_stall = exp_stall;
    endtask

    // Issues one instruction, holding it in ID while a stall is requested.
    task automatic issue(input logic [4:0] rs, input logic ur, input logic [4:0] rt,
                         input logic ut, input logic [4:0] rd, input logic we,
                         input logic ld, input logic fl);
        logic st;
        id_rs = rs; id_usa_rs = ur; id_rt = rt; id_usa_rt = ut;
        id_rd = rd; id_escreve_reg = we; id_le_mem = ld; flush = fl;
        for (int k = 0; k < 4; k++) begin
            cycle(st);
            if (!st) break;
            if (k == 3) check("stall_bound", 32'd1, 32'd0);
        end
        flush = 1'b0;
    endtask

    task automatic nop();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        id_rs = 0; id_rt = 0; id_rd = 0;
        id_usa_rs = 0; id_usa_rt = 0; id_escreve_reg = 0; id_le_mem = 0; flush = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        check("rst_sel_a", 32'(seletor_a), 32'd0);
        check("rst_sel_b", 32'(seletor_b), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
`ifdef FWD_STALL_COUNT_EN
        check("rst_counter", 32'(contador_stalls), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;

        // EX forward, one-gap MEM forward, two-gap register file
        issue(5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        issue(5'd8, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("fwd_ex_a", 32'(seletor_a), 32'd1);
        issue(5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        nop();
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        check("fwd_mem_a", 32'(seletor_a), 32'd2);
        issue(5'd5, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        nop();
        nop();
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        check("fwd_none_a", 32'(seletor_a), 32'd0);

        // EX beats MEM on a double writer; $zero never forwards
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        issue(5'd1, 1'b1, 5'd9, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("fwd_prio_b", 32'(seletor_b), 32'd1);
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
        check("fwd_zero_a", 32'(seletor_a), 32'd0);
        check("fwd_zero_b", 32'(seletor_b), 32'd0);

        // load-use: one stall, bubble, then MEM/WB forward
        nop();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
        issue(5'd10, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        check("ld_use_a", 32'(seletor_a), 32'd2);
`ifdef FWD_STALL_COUNT_EN
        check("ld_use_cnt", 32'(contador_stalls), 32'd1);
`endif

        // flush overrides the load-use stall
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
        issue(5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1);
        check("flush_sel_a", 32'(seletor_a), 32'd0);
`ifdef FWD_STALL_COUNT_EN
        check("flush_cnt", 32'(contador_stalls), 32'd1);
`endif
        issue(5'd11, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        check("flush_no_fwd", 32'(seletor_a), 32'd0);

        // unused rt matching a load in EX
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        id_rs = 5'd1; id_usa_rs = 1'b1; id_rt = 5'd12; id_usa_rt = 1'b0;
        #1;
        check("usa_rt0_stall", 32'(stall), 32'd0);
        issue(5'd1, 1'b1, 5'd12, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        check("usa_rt0_sel_b", 32'(seletor_b), 32'd0);

        // random stream over a small register range
        for (int i = 0; i < 60; i++) begin
            issue(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

`ifdef FWD_STALL_COUNT_EN
        begin
            logic [3:0] start;
            start = m_cnt;
            for (int i = 0; i < 16; i++) begin
                issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0);
                issue(5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
            end
            check("cnt_wrap", 32'(contador_stalls), 32'(start));
        end
`endif

        // reset mid-stream clears selectors, stall and in-flight tags at once
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        check("pre_rst_sel_a", 32'(seletor_a), 32'd1);
        id_rs = 5'd8; id_usa_rs = 1'b1; id_usa_rt = 1'b0;
        #1;
        check("pre_rst_stall", 32'(stall), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_sel_a", 32'(seletor_a), 32'd0);
        check("mid_rst_sel_b", 32'(seletor_b), 32'd0);
        check("mid_rst_stall", 32'(stall), 32'd0);
        model_clear();
`ifdef FWD_STALL_COUNT_EN
        check("mid_rst_cnt", 32'(contador_stalls), 32'd0);
`endif
        @(negedge clock);
        reset = 1'b0;
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        check("post_rst_sel_a", 32'(seletor_a), 32'd0);

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
